// File: rtl/serial_chunk_adder.sv
// rtl/serial_chunk_adder.sv - chunk-serial a+b+cin adder with valid/ready handshakes
// Adds CHUNK bits per clock, rippling the carry between beats through a register.
module serial_chunk_adder #(
  parameter int WIDTH  = 16,
  parameter int CHUNK  = 4,
  parameter bit SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);
  localparam int NBEATS = WIDTH / CHUNK;
  localparam int CW = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [CW-1:0] LAST = CW'(NBEATS - 1);

  generate
    if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
      $error("serial_chunk_adder: WIDTH must be a multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;

  // Operands shift right each beat so the active chunk always sits in the low bits.
  logic [CHUNK:0]   beat_add;
  logic [WIDTH-1:0] sum_shift;
  logic             msb_carry_in;

  assign beat_add = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_q};
  assign msb_carry_in = beat_add[CHUNK-1] ^ a_q[CHUNK-1] ^ b_q[CHUNK-1];

  // Result chunks enter from the top; after NBEATS beats the sum is fully aligned.
  generate
    if (CHUNK == WIDTH) begin : g_one_beat
      assign sum_shift = beat_add[CHUNK-1:0];
    end else begin : g_multi_beat
      assign sum_shift = {beat_add[CHUNK-1:0], sum_q[WIDTH-1:CHUNK]};
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        sum_d   = sum_shift;
        carry_d = beat_add[CHUNK];
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          cout_d  = beat_add[CHUNK];
          ovf_d   = SIGNED ? (msb_carry_in ^ beat_add[CHUNK]) : beat_add[CHUNK];
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_chunk_adder.sv
// tb/tb_serial_chunk_adder.sv - scoreboard bench for serial_chunk_adder
// Two 16-bit DUTs (unsigned/signed flags) share stimulus; two 4-bit DUTs run exhaustively.
module tb_serial_chunk_adder;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
    logic        ovs;
  } vec_t;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovs;
  } exp16_t;

  logic        in_valid, cin, out_ready;
  logic [15:0] a, b;
  logic        in_ready_u, out_valid_u, cout_u, ovf_u, busy_u;
  logic        in_ready_s, out_valid_s, cout_s, ovf_s, busy_s;
  logic [15:0] sum_u, sum_s;

  logic       in_valid_n  [2];
  logic [3:0] a_n         [2];
  logic [3:0] b_n         [2];
  logic       cin_n       [2];
  logic       out_ready_n [2] = '{1'b1, 1'b1};
  logic       in_ready_n  [2];
  logic       out_valid_n [2];
  logic [3:0] sum_n       [2];
  logic       cout_n      [2];
  logic       ovf_n       [2];
  logic       busy_n      [2];

  serial_chunk_adder #(.WIDTH(16), .CHUNK(4), .SIGNED(1'b0)) u_w16u (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_u),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid_u), .out_ready(out_ready),
    .sum(sum_u), .cout(cout_u), .ovf(ovf_u), .busy(busy_u));

  serial_chunk_adder #(.WIDTH(16), .CHUNK(4), .SIGNED(1'b1)) u_w16s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid_s), .out_ready(out_ready),
    .sum(sum_s), .cout(cout_s), .ovf(ovf_s), .busy(busy_s));

  serial_chunk_adder #(.WIDTH(4), .CHUNK(1), .SIGNED(1'b1)) u_w4c1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_n[0]), .in_ready(in_ready_n[0]),
    .a(a_n[0]), .b(b_n[0]), .cin(cin_n[0]), .out_valid(out_valid_n[0]),
    .out_ready(out_ready_n[0]), .sum(sum_n[0]), .cout(cout_n[0]), .ovf(ovf_n[0]),
    .busy(busy_n[0]));

  serial_chunk_adder #(.WIDTH(4), .CHUNK(4), .SIGNED(1'b0)) u_w4c4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_n[1]), .in_ready(in_ready_n[1]),
    .a(a_n[1]), .b(b_n[1]), .cin(cin_n[1]), .out_valid(out_valid_n[1]),
    .out_ready(out_ready_n[1]), .sum(sum_n[1]), .cout(cout_n[1]), .ovf(ovf_n[1]),
    .busy(busy_n[1]));

  exp16_t     q16 [$];
  logic [5:0] q4a [$];
  logic [5:0] q4b [$];
  logic [5:0] e4;
  bit         rnd_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic vec_t mk(input logic [15:0] av, input logic [15:0] bv, input logic cv,
                              input logic [15:0] s, input logic c, input logic o);
    mk = {av, bv, cv, s, c, o};
  endfunction

  task automatic drive16(input vec_t v, input bit push);
    bit     ok = 1'b0;
    exp16_t e;
    a = v.a; b = v.b; cin = v.cin; in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready_u) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (!ok) begin
      n_checks++; n_err++;
      $display("FAIL w16_accept_timeout: in_ready stayed 0, expected 1");
    end else if (push) begin
      e.sum = v.sum; e.cout = v.cout; e.ovs = v.ovs;
      q16.push_back(e);
    end
  endtask

  task automatic wait_valid16(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (out_valid_u) begin ok = 1'b1; break; end
    end
    check(name, {31'd0, ok}, 32'd1);
  endtask

  task automatic run4(input int k);
    logic [4:0] full;
    logic [3:0] av, bv;
    logic       cv;
    logic [5:0] e;
    bit         ok;
    for (int x = 0; x < 512; x++) begin
      av = 4'(x >> 5); bv = 4'(x >> 1); cv = x[0];
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      full = {1'b0, av} + {1'b0, bv} + {4'b0, cv};
      e[4:0] = full;
      e[5] = (k == 0) ? ((av[3] == bv[3]) && (full[3] != av[3])) : full[4];
      a_n[k] = av; b_n[k] = bv; cin_n[k] = cv; in_valid_n[k] = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (in_ready_n[k]) begin ok = 1'b1; break; end
      end
      @(posedge clk); #1;
      in_valid_n[k] = 1'b0;
      if (!ok) begin
        n_checks++; n_err++;
        $display("FAIL w4_%0d_accept_timeout: in_ready stayed 0, expected 1", k);
      end else if (k == 0) q4a.push_back(e);
      else q4b.push_back(e);
    end
  endtask

  always @(posedge clk) begin
    #1;
    for (int k = 0; k < 2; k++) out_ready_n[k] = rnd_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Outputs are compared against the queue head on every cycle they are valid, so held values are checked too.
  always @(negedge clk) begin
    if (rst_n && (out_valid_u || out_valid_s)) begin
      if (q16.size() == 0) begin
        n_checks++; n_err++;
        $display("FAIL w16_unexpected_valid: got out_valid=1 with empty scoreboard, expected 0");
      end else begin
        check("w16_valid_pair", {30'd0, out_valid_u, out_valid_s}, 32'd3);
        check("w16u_sum",  sum_u,  q16[0].sum);
        check("w16u_cout", cout_u, q16[0].cout);
        check("w16u_ovf",  ovf_u,  q16[0].cout);
        check("w16u_busy", busy_u, 1);
        check("w16s_sum",  sum_s,  q16[0].sum);
        check("w16s_cout", cout_s, q16[0].cout);
        check("w16s_ovf",  ovf_s,  q16[0].ovs);
        check("w16s_busy", busy_s, 1);
        if (out_ready) void'(q16.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 2; k++) begin
        if (out_valid_n[k]) begin
          if (((k == 0) ? q4a.size() : q4b.size()) == 0) begin
            n_checks++; n_err++;
            $display("FAIL w4_%0d_unexpected_valid: got out_valid=1 with empty scoreboard, expected 0", k);
          end else begin
            e4 = (k == 0) ? q4a[0] : q4b[0];
            check($sformatf("w4_%0d_sum", k),  sum_n[k],  e4[3:0]);
            check($sformatf("w4_%0d_cout", k), cout_n[k], e4[4]);
            check($sformatf("w4_%0d_ovf", k),  ovf_n[k],  e4[5]);
            check($sformatf("w4_%0d_busy", k), busy_n[k], 1);
            if (out_ready_n[k]) begin
              if (k == 0) void'(q4a.pop_front());
              else void'(q4b.pop_front());
            end
          end
        end
      end
    end
  end

  initial begin
    vec_t vecs [10];
    int   lat;
    vecs[0] = mk(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);
    vecs[1] = mk(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    vecs[2] = mk(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
    vecs[3] = mk(16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0);
    vecs[4] = mk(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    vecs[5] = mk(16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1);
    vecs[6] = mk(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    vecs[7] = mk(16'hA5A5, 16'h5A5A, 1'b1, 16'h0000, 1'b1, 1'b0);
    vecs[8] = mk(16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0, 1'b0);
    vecs[9] = mk(16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1, 1'b1);

    rst_n = 1'b0; in_valid = 1'b1; a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      in_valid_n[k] = 1'b0; a_n[k] = '0; b_n[k] = '0; cin_n[k] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",  in_ready_u,  1);
    check("rst_out_valid", out_valid_u, 0);
    check("rst_busy",      busy_u,      0);
    check("rst_sum",       sum_u,       0);
    check("rst_cout",      cout_u,      0);
    check("rst_ovf",       ovf_s,       0);
    in_valid = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_busy", busy_u, 0);

    drive16(mk(16'hFFFF, 16'hFFFF, 1'b1, 16'h0000, 1'b0, 1'b0), 1'b0);
    @(posedge clk); #1;
    check("midrun_busy", busy_u, 1);
    rst_n = 1'b0; #1;
    check("midrun_rst_out_valid", out_valid_u, 0);
    check("midrun_rst_sum",       sum_u,       0);
    check("midrun_rst_in_ready",  in_ready_u,  1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive16(vecs[0], 1'b1);

    drive16(vecs[1], 1'b1);
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (out_valid_u) begin lat = i; break; end
    end
    check("latency_edges", lat, 4);
    @(posedge clk); #1;
    check("done_one_cycle_valid", out_valid_u, 0);
    check("done_one_cycle_ready", in_ready_u,  1);

    for (int i = 2; i < 8; i++) drive16(vecs[i], 1'b1);

    drive16(mk(16'h0F0F, 16'hF0F0, 1'b0, 16'hFFFF, 1'b0, 1'b0), 1'b1);
    out_ready = 1'b0;
    wait_valid16("middone_reached");
    rst_n = 1'b0; #1;
    check("middone_rst_out_valid", out_valid_u, 0);
    check("middone_rst_in_ready",  in_ready_u,  1);
    q16.delete();
    @(posedge clk); #1;
    rst_n = 1'b1; out_ready = 1'b1;

    drive16(vecs[8], 1'b1);
    out_ready = 1'b0;
    wait_valid16("bp_reached");
    a = vecs[9].a; b = vecs[9].b; cin = vecs[9].cin; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_in_ready",  in_ready_u,  0);
      check("bp_out_valid", out_valid_u, 1);
    end
    out_ready = 1'b1;
    drive16(vecs[9], 1'b1);

    rnd_en = 1'b1;
    fork
      run4(0);
      run4(1);
    join
    rnd_en = 1'b0;
    for (int i = 0; i < 200 && (q16.size() + q4a.size() + q4b.size()) != 0; i++) begin
      @(posedge clk); #1;
    end
    check("drain_w16",   q16.size(), 0);
    check("drain_w4_c1", q4a.size(), 0);
    check("drain_w4_c4", q4b.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
